// File: rtl/aes_mmio_slave.sv
// ============================================================================
// Module   : aes_mmio_slave
// Purpose  : Bus-side responder for the AES/DMA window: CTRL/CONFIG registers,
//            2-entry DMA descriptor FIFO, AES start sequencing, latent STATUS reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mmio_slave #(
    parameter logic [31:0] ADDR_CTRL     = 32'h4000_0000,
    parameter logic [31:0] ADDR_CONFIG   = 32'h4000_0004,
    parameter logic [31:0] ADDR_ADDR_SRC = 32'h4000_0008,
    parameter logic [31:0] ADDR_START    = 32'h4000_000C,
    parameter logic [31:0] ADDR_STATUS   = 32'h4000_0010,
    parameter int unsigned RD_LAT        = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cs_i,
    input  logic         we_i,
    input  logic [31:0]  addr_i,
    input  logic [127:0] wdata_i,
    output logic [127:0] rdata_o,
    output logic         rvalid_o,
    output logic [31:0]  ctrl_o,
    output logic [31:0]  config_o,
    output logic         dma_valid_o,
    output logic [31:0]  dma_src_o,
    output logic [31:0]  dma_dst_o,
    output logic [31:0]  dma_cfg_o,
    input  logic         dma_ready_i,
    output logic         start_o,
    input  logic         core_busy_i,
    input  logic         core_done_i
);

    localparam logic [3:0] C_LAT_LOAD  = 4'(RD_LAT - 1);
    localparam logic [2:0] C_SEL_CTRL   = 3'd0;
    localparam logic [2:0] C_SEL_CONFIG = 3'd1;
    localparam logic [2:0] C_SEL_ZERO   = 3'd2;
    localparam logic [2:0] C_SEL_STATUS = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_rd_sel;
    logic [31:0] r_ctrl;
    logic [31:0] r_config;
    logic        r_start_pend;
    logic        r_done;
    logic        r_err;

    logic [31:0] r_src [2];
    logic [31:0] r_dst [2];
    logic [31:0] r_cfg [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_hit_ctrl, w_hit_config, w_hit_src, w_hit_start, w_hit_status;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd_req;
    logic [2:0]  w_sel;
    logic        w_full;
    logic        w_nonempty;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push_ok;
    logic        w_push_drop;
    logic        w_fire;
    logic        w_status_resp;
    logic [31:0] w_status;
    logic [127:0] w_rdata;
    logic        w_unused_wdata;

    assign w_hit_ctrl   = cs_i && (addr_i == ADDR_CTRL);
    assign w_hit_config = cs_i && (addr_i == ADDR_CONFIG);
    assign w_hit_src    = cs_i && (addr_i == ADDR_ADDR_SRC);
    assign w_hit_start  = cs_i && (addr_i == ADDR_START);
    assign w_hit_status = cs_i && (addr_i == ADDR_STATUS);
    assign w_hit = w_hit_ctrl | w_hit_config | w_hit_src | w_hit_start | w_hit_status;

    assign w_wr     = w_hit & we_i;
    assign w_rd_req = w_hit & ~we_i & (r_state == S_IDLE);

    always_comb begin
        w_sel = C_SEL_ZERO;
        if (w_hit_ctrl)        w_sel = C_SEL_CTRL;
        else if (w_hit_config) w_sel = C_SEL_CONFIG;
        else if (w_hit_status) w_sel = C_SEL_STATUS;
    end

    assign w_full      = (r_count == 2'd2);
    assign w_nonempty  = (r_count != 2'd0);
    assign w_pop       = w_nonempty & dma_ready_i;
    assign w_push_req  = w_wr & w_hit_src & wdata_i[96];
    // A pop in the same cycle frees the slot the full FIFO is about to overwrite.
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_push_drop = w_push_req & w_full & ~w_pop;

    assign w_fire        = r_start_pend & ~w_nonempty & ~core_busy_i;
    assign w_status_resp = (r_state == S_RESP) && (r_rd_sel == C_SEL_STATUS);

    assign w_status = {27'd0, r_err, w_full, w_nonempty, r_done, core_busy_i | r_start_pend};
    assign w_unused_wdata = ^wdata_i[127:97];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rd_sel <= C_SEL_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_req) begin
                        r_state  <= S_WAIT;
                        r_cnt    <= C_LAT_LOAD;
                        r_rd_sel <= w_sel;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl       <= 32'd0;
            r_config     <= 32'd0;
            r_start_pend <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_wr && w_hit_ctrl)   r_ctrl   <= wdata_i[31:0];
            if (w_wr && w_hit_config) r_config <= wdata_i[31:0];

            // Firing takes priority, so a START written while pending is absorbed.
            if (w_fire)                  r_start_pend <= 1'b0;
            else if (w_wr && w_hit_start) r_start_pend <= 1'b1;

            if (core_done_i)        r_done <= 1'b1;
            else if (w_status_resp) r_done <= 1'b0;

            if (w_push_drop)        r_err <= 1'b1;
            else if (w_status_resp) r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_src[i] <= 32'd0;
                r_dst[i] <= 32'd0;
                r_cfg[i] <= 32'd0;
            end
        end else begin
            if (w_push_ok) begin
                r_src[r_wr_ptr] <= wdata_i[31:0];
                r_dst[r_wr_ptr] <= wdata_i[63:32];
                r_cfg[r_wr_ptr] <= wdata_i[95:64];
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop};
        end
    end

    always_comb begin
        w_rdata = 128'd0;
        if (r_state == S_RESP) begin
            case (r_rd_sel)
                C_SEL_CTRL:   w_rdata = {96'd0, r_ctrl};
                C_SEL_CONFIG: w_rdata = {96'd0, r_config};
                C_SEL_STATUS: w_rdata = {96'd0, w_status};
                default:      w_rdata = 128'd0;
            endcase
        end
    end

    assign rdata_o     = w_rdata;
    assign rvalid_o    = (r_state == S_RESP);
    assign ctrl_o      = r_ctrl;
    assign config_o    = r_config;
    assign dma_valid_o = w_nonempty;
    assign dma_src_o   = r_src[r_rd_ptr];
    assign dma_dst_o   = r_dst[r_rd_ptr];
    assign dma_cfg_o   = r_cfg[r_rd_ptr];
    assign start_o     = w_fire;

endmodule

`default_nettype wire
